// File: rtl/efb_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the EFB register port.
// Cycle-locked tenancy, round-robin ties, per-tenancy stb watchdog.
module efb_wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       efb_cyc_o,
  output logic       efb_stb_o,
  output logic       efb_we_o,
  output logic [7:0] efb_adr_o,
  output logic [7:0] efb_dat_o,
  input  logic [7:0] efb_dat_i,
  input  logic       efb_ack_i,
  output logic [1:0] grant_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner;
  logic       last_owner;
  logic [7:0] cnt;

  logic busy;
  logic own_cyc;
  logic own_stb;
  logic tmo_slot;
  logic tmo;
  logic own_ack;

  assign busy    = (state == BUSY);
  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner ? m1_stb_i : m0_stb_i;

  // Timeout slot is the TIMEOUT-th waiting cycle; stb is masked on the
  // counter alone so efb_stb_o never depends on efb_ack_i.
  assign tmo_slot = busy && own_stb && (cnt == TMO_LAST);
  assign tmo      = tmo_slot && !efb_ack_i;
  assign own_ack  = busy && efb_ack_i;

  assign efb_cyc_o = busy;
  assign efb_stb_o = busy && own_stb && !tmo_slot;
  assign efb_we_o  = busy && (owner ? m1_we_i : m0_we_i);
  assign efb_adr_o = busy ? (owner ? m1_adr_i : m0_adr_i) : 8'h00;
  assign efb_dat_o = busy ? (owner ? m1_dat_i : m0_dat_i) : 8'h00;

  assign m0_dat_o = efb_dat_i;
  assign m1_dat_o = efb_dat_i;
  assign m0_ack_o = own_ack && !owner;
  assign m1_ack_o = own_ack && owner;
  assign m0_err_o = tmo && !owner;
  assign m1_err_o = tmo && owner;

  assign grant_o = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (m0_cyc_i && m1_cyc_i) begin
            state <= BUSY;
            owner <= ~last_owner;
          end else if (m0_cyc_i || m1_cyc_i) begin
            state <= BUSY;
            owner <= m1_cyc_i;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            state      <= IDLE;
            last_owner <= owner;
            cnt        <= 8'd0;
          end else if (efb_ack_i || !own_stb || tmo) begin
            cnt <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Directed bench for efb_wb_arbiter with TIMEOUT=4.
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_efb_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [7:0] m0_adr_i = 0, m0_dat_i = 0;
  logic [7:0] m0_dat_o;
  logic       m0_ack_o, m0_err_o;
  logic       m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [7:0] m1_adr_i = 0, m1_dat_i = 0;
  logic [7:0] m1_dat_o;
  logic       m1_ack_o, m1_err_o;
  logic       efb_cyc_o, efb_stb_o, efb_we_o;
  logic [7:0] efb_adr_o, efb_dat_o;
  logic [7:0] efb_dat_i = 0;
  logic       efb_ack_i = 0;
  logic [1:0] grant_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  efb_wb_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .efb_cyc_o(efb_cyc_o), .efb_stb_o(efb_stb_o), .efb_we_o(efb_we_o),
    .efb_adr_o(efb_adr_o), .efb_dat_o(efb_dat_o),
    .efb_dat_i(efb_dat_i), .efb_ack_i(efb_ack_i),
    .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_cyc", 32'(efb_cyc_o), 32'h0);
    chk("rst_stb", 32'(efb_stb_o), 32'h0);
    chk("rst_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'h0);
    step();
    rst = 1'b0;
    step();

    // tie after reset -> m0, then m1 after one idle cycle
    m0_cyc_i = 1; m1_cyc_i = 1;
    #1;
    chk("tie_pre_grant", 32'(grant_o), 32'h0);
    step();
    chk("tie_grant_m0", 32'(grant_o), 32'h1);
    chk("tie_cyc", 32'(efb_cyc_o), 32'h1);
    m0_cyc_i = 0;
    step();
    chk("tie_idle_grant", 32'(grant_o), 32'h0);
    chk("tie_idle_cyc", 32'(efb_cyc_o), 32'h0);
    step();
    chk("tie_grant_m1", 32'(grant_o), 32'h2);
    m1_cyc_i = 0;
    step();
    chk("tie_release", 32'(grant_o), 32'h0);

    // single read by m1
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 8'h54; m1_we_i = 0;
    step();
    chk("rd_grant", 32'(grant_o), 32'h2);
    chk("rd_adr", 32'(efb_adr_o), 32'h54);
    chk("rd_stb", 32'(efb_stb_o), 32'h1);
    chk("rd_we", 32'(efb_we_o), 32'h0);
    chk("rd_wait_ack", 32'(m1_ack_o), 32'h0);
    step();
    step();
    efb_ack_i = 1; efb_dat_i = 8'hA5;
    #1;
    chk("rd_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("rd_m1_dat", 32'(m1_dat_o), 32'hA5);
    chk("rd_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("rd_m1_err", 32'(m1_err_o), 32'h0);
    chk("rd_m0_dat", 32'(m0_dat_o), 32'hA5);
    step();
    efb_ack_i = 0;
    #1;
    chk("rd_ack_pulse", 32'(m1_ack_o), 32'h0);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    chk("rd_release", 32'(grant_o), 32'h0);

    // lock: m0 owns across 10 acked writes while m1 waits
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
    m0_adr_i = 8'h10; m0_dat_i = 8'h3C;
    step();
    chk("lk_grant", 32'(grant_o), 32'h1);
    chk("lk_we", 32'(efb_we_o), 32'h1);
    chk("lk_dat", 32'(efb_dat_o), 32'h3C);
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 8'h77;
    for (int i = 0; i < 10; i++) begin
      efb_ack_i = 1;
      #1;
      chk("lk_hold", 32'(grant_o), 32'h1);
      chk("lk_m0_ack", 32'(m0_ack_o), 32'h1);
      chk("lk_m1_ack", 32'(m1_ack_o), 32'h0);
      step();
    end
    efb_ack_i = 0;
    chk("lk_adr_m0", 32'(efb_adr_o), 32'h10);
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    step();
    chk("lk_gap", 32'(grant_o), 32'h0);
    step();
    chk("lk_m1_won", 32'(grant_o), 32'h2);
    chk("lk_m1_adr", 32'(efb_adr_o), 32'h77);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();

    // watchdog: err on 4th waiting cycle, stb masked
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    chk("to_w1_stb", 32'(efb_stb_o), 32'h1);
    chk("to_w1_err", 32'(m0_err_o), 32'h0);
    step();
    step();
    chk("to_w3_err", 32'(m0_err_o), 32'h0);
    step();
    chk("to_w4_err", 32'(m0_err_o), 32'h1);
    chk("to_w4_stb", 32'(efb_stb_o), 32'h0);
    chk("to_w4_m1err", 32'(m1_err_o), 32'h0);
    step();
    chk("to_after_err", 32'(m0_err_o), 32'h0);
    chk("to_after_stb", 32'(efb_stb_o), 32'h1);
    step();
    step();
    step();
    efb_ack_i = 1;
    #1;
    chk("to_ack_wins_ack", 32'(m0_ack_o), 32'h1);
    chk("to_ack_wins_err", 32'(m0_err_o), 32'h0);
    step();
    efb_ack_i = 0;

    // async reset mid-tenancy, then tie goes to m0
    m1_cyc_i = 1;
    #3;
    chk("ar_busy", 32'(efb_cyc_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("ar_cyc", 32'(efb_cyc_o), 32'h0);
    chk("ar_stb", 32'(efb_stb_o), 32'h0);
    chk("ar_grant", 32'(grant_o), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("ar_tie_m0", 32'(grant_o), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/efb_wb_arbiter.md
EFB_WB_ARBITER -- requirements
Module: efb_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles an owner's stb may wait for ack before an error is returned (1..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mN_cyc_i  input  1  Wishbone cycle request, master N (N=0,1; N=0 is the UFM reader side).
REQ-005 mN_stb_i  input  1  strobe, master N.
REQ-006 mN_we_i  input  1  write enable, master N.
REQ-007 mN_adr_i  input  8  EFB register address, master N.
REQ-008 mN_dat_i  input  8  write data, master N.
REQ-009 mN_dat_o  output  8  read data to master N.
REQ-010 mN_ack_o  output  1  acknowledge to master N.
REQ-011 mN_err_o  output  1  timeout error to master N.
REQ-012 efb_cyc_o, efb_stb_o, efb_we_o  output  1 each  Wishbone controls to EFB.
REQ-013 efb_adr_o, efb_dat_o  output  8 each  address/write data to EFB.
REQ-014 efb_dat_i  input  8  EFB read data.
REQ-015 efb_ack_i  input  1  EFB acknowledge.
REQ-016 grant_o  output  2  one-hot current owner (bit N = master N); 00 when idle.

Function
REQ-017 FSM states IDLE and BUSY; registered owner bit and last_owner bit.
REQ-018 IDLE: all efb_* outputs 0, grant_o=00, all mN_ack_o/mN_err_o 0.
REQ-019 IDLE with exactly one mN_cyc_i high: next cycle BUSY, owner=N.
REQ-020 IDLE with both cyc high: owner = ~last_owner (round robin).
REQ-021 Grant latency: efb_cyc_o rises exactly one cycle after the winning mN_cyc_i is sampled high in IDLE.
REQ-022 BUSY: efb_cyc_o=1; efb_stb_o, efb_we_o, efb_adr_o, efb_dat_o combinationally follow the owner's inputs.
REQ-023 BUSY: efb_ack_i routed only to owner's mN_ack_o; non-owner ack/err always 0.
REQ-024 mN_dat_o = efb_dat_i for both masters at all times (data qualified by ack).
REQ-025 Tenancy is cycle-locked: ownership held while owner's cyc_i high, regardless of other requests.
REQ-026 Owner cyc_i sampled low in BUSY: next cycle IDLE, last_owner=owner; min one idle cycle (efb_cyc_o low) between tenancies.
REQ-027 Owner dropping cyc_i with stb pending and no ack: transfer abandoned, released per REQ-026, no err.
REQ-028 Watchdog: 8-bit counter, cleared in IDLE, on efb_ack_i, or when owner stb low; increments each BUSY cycle owner stb high without ack.
REQ-029 Counter reaching TIMEOUT: owner mN_err_o pulses high one cycle, efb_stb_o forced 0 that cycle, counter cleared.
REQ-030 efb_ack_i and timeout in the same cycle: ack wins, no err.
REQ-031 Non-owner requests in BUSY are ignored; no ack/err returned until granted.

Reset
REQ-032 rst high: immediately (no clock) state IDLE, owner=0, last_owner=1, counter=0; all outputs 0, grant_o=00.
REQ-033 rst mid-tenancy: efb_cyc_o/efb_stb_o drop asynchronously; after release, first arbitration follows REQ-019/020 with last_owner=1 (m0 wins a tie).

Verification
REQ-034 Tie after reset: m0,m1 cyc high same cycle -> grant_o=01 next cycle; m0 drops cyc -> one idle cycle -> grant_o=10.
REQ-035 Single read: m1 cyc/stb, adr=0x54, EFB acks after 3 cycles with 0xA5 -> m1_ack_o one cycle, m1_dat_o=0xA5, m0_ack_o stays 0.
REQ-036 Lock: m0 owns, m1 requests mid-tenancy across 10 acked transfers -> grant_o stays 01 throughout; m1 granted only after m0 releases.
REQ-037 Timeout: TIMEOUT=4, owner stb high, ack never -> m0_err_o pulses on 4th waiting cycle, efb_stb_o low that cycle; ack on cycle 4 instead -> ack, no err.
REQ-038 Async reset: assert rst between clock edges while BUSY -> efb_cyc_o=0 and grant_o=00 before next edge; release -> tie grants m0.
